// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - TLB widths, entry types and field positions
package tlb_pkg;
    localparam int IDX_W = 13;
    localparam int VPN_W = 64;
    localparam int PTE_W = 64;
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int PTE_PRESENT_BIT = 0;

    typedef logic [VPN_W-1:0] vpn_t;
    typedef logic [PTE_W-1:0] pte_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic valid;
        vpn_t tag;
        pte_t pte;
    } tlb_entry_t;
endpackage

// File: rtl/tlb_entry_ram.sv
// rtl/tlb_entry_ram.sv - tag and pte storage, synchronous write, asynchronous read
module tlb_entry_ram
    import tlb_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [VPN_W-1:0] wtag,
    input  logic [PTE_W-1:0] wpte,
    input  logic [IDX_W-1:0] raddr,
    output logic [VPN_W-1:0] rtag,
    output logic [PTE_W-1:0] rpte
);
    vpn_t tag_mem [ENTRIES];
    pte_t pte_mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[waddr] <= wtag;
            pte_mem[waddr] <= wpte;
        end
    end

    // No read bypass: a same-index write becomes visible only after the edge.
    assign rtag = tag_mem[raddr];
    assign rpte = pte_mem[raddr];
endmodule

// File: rtl/tlb.sv
// rtl/tlb.sv - direct-mapped TLB with combinational lookup and walker fill port
module tlb
    import tlb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [VPN_W-1:0] pageno,
    input  logic [VPN_W-1:0] wrpageno,
    input  logic [PTE_W-1:0] tableentry,
    input  logic [IDX_W-1:0] wraddr,
    input  logic             write,
    output logic             hit,
    output logic [PTE_W-1:0] data
);
    logic [ENTRIES-1:0] valid;
    idx_t               idx;
    vpn_t               rtag;
    pte_t               rpte;
    tlb_entry_t         entry;
    logic               we;

    assign idx = pageno[IDX_W-1:0];
    assign we  = write & ~reset;

    // Valid bits live outside the RAM so reset can clear every entry at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (write) begin
            valid[wraddr] <= 1'b1;
        end
    end

    tlb_entry_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wraddr),
        .wtag  (wrpageno),
        .wpte  (tableentry),
        .raddr (idx),
        .rtag  (rtag),
        .rpte  (rpte)
    );

    always_comb begin
        entry.valid = valid[idx];
        entry.tag   = rtag;
        entry.pte   = rpte;
    end

    // Gating data on hit keeps uninitialised RAM contents off the outputs.
    assign hit  = entry.valid & (entry.tag == pageno) & entry.pte[PTE_PRESENT_BIT];
    assign data = hit ? entry.pte : '0;
endmodule

// File: tb/tb_tlb.sv
// tb/tb_tlb.sv - scoreboard bench for tlb with directed lookup/fill vectors
module tb_tlb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pageno = '0;
    logic [63:0] wrpageno = '0;
    logic [63:0] tableentry = '0;
    logic [12:0] wraddr = '0;
    logic        write = 1'b0;
    logic        hit;
    logic [63:0] data;

    typedef struct {
        string       name;
        logic        h;
        logic [63:0] d;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   checks = 0;
    int   failures = 0;

    tlb dut (
        .clk        (clk),
        .reset      (reset),
        .pageno     (pageno),
        .wrpageno   (wrpageno),
        .tableentry (tableentry),
        .wraddr     (wraddr),
        .write      (write),
        .hit        (hit),
        .data       (data)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation each time the stimulus presents a lookup.
    initial begin
        forever begin
            exp_t e;
            @(sample_ev);
            #1;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL %s: no expectation queued (hit=%b data=%h)", "scoreboard", hit, data);
            end else begin
                e = q.pop_front();
                if (hit !== e.h || data !== e.d) begin
                    failures++;
                    $display("FAIL %s: got hit=%b data=%h, want hit=%b data=%h",
                             e.name, hit, data, e.h, e.d);
                end
            end
        end
    end

    task automatic check(input logic [63:0] vpn, input logic eh, input logic [63:0] ed,
                         input string name);
        exp_t e;
        pageno = vpn;
        e.name = name;
        e.h = eh;
        e.d = ed;
        q.push_back(e);
        -> sample_ev;
        #2;
    endtask

    task automatic do_write(input logic [12:0] a, input logic [63:0] vpn, input logic [63:0] pte);
        @(negedge clk);
        wraddr = a;
        wrpageno = vpn;
        tableentry = pte;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    initial begin
        #1;
        check(64'h0, 1'b0, 64'h0, "reset_pg0");
        check(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, "reset_pgmax");
        @(negedge clk);
        reset = 1'b0;
        check(64'h0, 1'b0, 64'h0, "post_reset_pg0");

        do_write(13'd0, 64'h0, 64'h0);
        check(64'h0, 1'b0, 64'h0, "not_present");

        do_write(13'd0, 64'h0, 64'h5001);
        check(64'h0, 1'b1, 64'h5001, "hit_pg0");
        check(64'h1, 1'b0, 64'h0, "miss_pg1");

        @(negedge clk);
        wraddr = 13'd1;
        wrpageno = 64'h1;
        tableentry = 64'h6001;
        write = 1'b1;
        check(64'h1, 1'b0, 64'h0, "rdw_before_edge");
        @(posedge clk);
        #1;
        write = 1'b0;
        check(64'h1, 1'b1, 64'h6001, "rdw_after_edge");
        check(64'h0, 1'b1, 64'h5001, "pg0_intact");

        do_write(13'd1, 64'h2001, 64'h7000);
        check(64'h2001, 1'b0, 64'h0, "alias_not_present");
        check(64'h1, 1'b0, 64'h0, "tag_overwritten");
        do_write(13'd2, 64'h5, 64'h9001);
        check(64'h5, 1'b0, 64'h0, "idx_mismatch_vpn");
        check(64'h2, 1'b0, 64'h0, "idx_mismatch_slot");
        do_write(13'd1, 64'h2001, 64'h7001);
        check(64'h2001, 1'b1, 64'h7001, "alias_hit");
        check(64'h1, 1'b0, 64'h0, "alias_old_tag");
        do_write(13'h1FFF, 64'hDEAD_0000_0000_1FFF, 64'hA001);
        check(64'hDEAD_0000_0000_1FFF, 1'b1, 64'hA001, "top_index_hit");
        check(64'hDEAD_0000_0000_3FFF, 1'b0, 64'h0, "top_index_tag_miss");

        @(negedge clk);
        wraddr = 13'd3;
        wrpageno = 64'h3;
        tableentry = 64'hB001;
        write = 1'b1;
        reset = 1'b1;
        check(64'h0, 1'b0, 64'h0, "async_reset_pg0");
        check(64'h2001, 1'b0, 64'h0, "async_reset_alias");
        @(negedge clk);
        reset = 1'b0;
        write = 1'b0;
        @(negedge clk);
        check(64'h3, 1'b0, 64'h0, "reset_beats_write");
        check(64'h0, 1'b0, 64'h0, "cleared_pg0");
        check(64'h2001, 1'b0, 64'h0, "cleared_alias");
        check(64'hDEAD_0000_0000_1FFF, 1'b0, 64'h0, "cleared_top");
        do_write(13'd0, 64'h0, 64'h5001);
        check(64'h0, 1'b1, 64'h5001, "rewrite_after_reset");

        for (int i = 0; i < 20 && q.size() != 0; i++) #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expectations left, want 0", "drain", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
